// File: rtl/shl_seq_shifter_if.sv
// Handshake and data bundle for the sequential left shifter/rotator.
// The master is the requesting controller and the slave is the shifter.
interface shl_seq_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic             rotate;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (
    output start, a, shamt, rotate,
    input  in_ready, done, out
  );

  modport slave (
    input  start, a, shamt, rotate,
    output in_ready, done, out
  );
endinterface

// File: rtl/shl_seq_shifter.sv
// Sequential 32-bit SLL/ROL unit that retires up to two bit positions per clock.
// Define SHL_ROTATE_EN to compile in rotate support; without it the block is SLL only.
module shl_seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic               clk,
  input  logic               rst,
  shl_seq_shifter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [SHW-1:0]   rem_q,   rem_d;
  logic [1:0]       fill2_s;
  logic             fill1_s;

`ifdef SHL_ROTATE_EN
  logic             rot_q,   rot_d;

  // Rotation refills the low end with the bits leaving the top.
  assign fill2_s = rot_q ? work_q[WIDTH-1:WIDTH-2] : 2'b00;
  assign fill1_s = rot_q ? work_q[WIDTH-1]         : 1'b0;
`else
  logic             rotate_unused_s;

  assign rotate_unused_s = bus.rotate;
  assign fill2_s         = 2'b00;
  assign fill1_s         = 1'b0;
`endif

  // State, work register and remaining-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= {WIDTH{1'b0}};
      rem_q   <= {SHW{1'b0}};
`ifdef SHL_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
`ifdef SHL_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, shift by two (or one on an odd tail), then report.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
`ifdef SHL_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          work_d  = bus.a;
          rem_d   = bus.shamt;
`ifdef SHL_ROTATE_EN
          rot_d   = bus.rotate;
`endif
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rem_q >= SHW'(2)) begin
          work_d = {work_q[WIDTH-3:0], fill2_s};
          rem_d  = rem_q - SHW'(2);
        end else if (rem_q == SHW'(1)) begin
          work_d = {work_q[WIDTH-2:0], fill1_s};
          rem_d  = {SHW{1'b0}};
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.out      = work_q;

endmodule

// File: tb/tb_shl_seq_shifter.sv
// Self-checking bench for shl_seq_shifter: arithmetic reference model checked every
// cycle, plus directed vectors with literal expected results and latencies.
module tb_shl_seq_shifter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  shl_seq_shifter_if #(.WIDTH(32), .SHW(5)) bus ();

  shl_seq_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: left shift via 64-bit arithmetic; rotation ORs back the spilled upper word.
  function automatic logic [31:0] ref_shl(input logic [31:0] x, input int s, input logic rot);
    logic [63:0] w;
    w = {32'h0000_0000, x} << s;
`ifdef SHL_ROTATE_EN
    return rot ? (w[31:0] | w[63:32]) : w[31:0];
`else
    return w[31:0];
`endif
  endfunction

  function automatic int ref_lat(input int s);
    return (s + 1) / 2 + 1;
  endfunction

  // Model: busy flag and edges counted since the accept edge.
  logic        m_busy;
  int          m_n;
  int          m_lat;
  logic [31:0] m_a;
  logic [31:0] m_res;
  logic [31:0] m_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_n    <= 0;
      m_lat  <= 0;
      m_a    <= 32'h0;
      m_res  <= 32'h0;
      m_out  <= 32'h0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy <= 1'b1;
        m_n    <= 0;
        m_lat  <= ref_lat(int'(bus.shamt));
        m_a    <= bus.a;
        m_res  <= ref_shl(bus.a, int'(bus.shamt), bus.rotate);
      end
    end else if (m_n == m_lat) begin
      m_busy <= 1'b0;
      m_out  <= m_res;
    end else begin
      m_n <= m_n + 1;
    end
  end

  always @(negedge clk) begin
    check("in_ready", {31'h0, bus.in_ready}, {31'h0, !m_busy});
    check("done",     {31'h0, bus.done},     {31'h0, (m_busy && m_n == m_lat)});
    if (!m_busy)            check("out_idle",   bus.out, m_out);
    else if (m_n == 0)      check("out_loaded", bus.out, m_a);
    else if (m_n == m_lat)  check("out_result", bus.out, m_res);
  end

  // Issue one request from posedge+2; returns at posedge+2 one edge after done.
  task automatic run_op(input logic [31:0] ai, input logic [4:0] sh, input logic rot,
                        input logic [31:0] exp_o, input int exp_lat, input bit poke);
    int edges;
    bit seen;
    bus.a      = ai;
    bus.shamt  = sh;
    bus.rotate = rot;
    bus.start  = 1'b1;
    @(posedge clk); #2;
    bus.start  = 1'b0;
    bus.a      = ~ai;
    bus.shamt  = ~sh;
    bus.rotate = ~rot;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk); edges++; #2;
      if (poke && edges == 3) begin
        bus.start = 1'b1;
        bus.a     = 32'h1234_5678;
        bus.shamt = 5'd1;
      end else if (poke && edges == 4) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", {31'h0, seen}, 32'h1);
    check("latency",   edges, exp_lat);
    check("result",    bus.out, exp_o);
    @(posedge clk); #2;
    check("ready_after", {31'h0, bus.in_ready}, 32'h1);
    check("hold_after",  bus.out, exp_o);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.a      = 32'h0;
    bus.shamt  = 5'd0;
    bus.rotate = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("rst_out",   bus.out, 32'h0);
    check("rst_done",  {31'h0, bus.done}, 32'h0);
    check("rst_ready", {31'h0, bus.in_ready}, 32'h1);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    run_op(32'h0000_0001, 5'd4,  1'b0, 32'h0000_0010, 3,  1'b0);
`ifdef SHL_ROTATE_EN
    run_op(32'hC000_0003, 5'd2,  1'b1, 32'h0000_000F, 2,  1'b0);
    run_op(32'h8000_0001, 5'd3,  1'b1, 32'h0000_000C, 3,  1'b0);
`else
    run_op(32'hC000_0003, 5'd2,  1'b1, 32'h0000_000C, 2,  1'b0);
    run_op(32'h8000_0001, 5'd3,  1'b1, 32'h0000_0008, 3,  1'b0);
`endif
    run_op(32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 1,  1'b0);
    run_op(32'hFFFF_FFFF, 5'd31, 1'b0, 32'h8000_0000, 17, 1'b1);
    run_op(32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 17, 1'b0);
    run_op(32'hA5A5_A5A5, 5'd1,  1'b0, 32'h4B4B_4B4A, 2,  1'b0);

    // Abort a long request with an asynchronous reset just after its third edge.
    bus.a     = 32'h0000_0001;
    bus.shamt = 5'd20;
    bus.rotate = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_out",   bus.out, 32'h0);
    check("abort_done",  {31'h0, bus.done}, 32'h0);
    check("abort_ready", {31'h0, bus.in_ready}, 32'h1);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'h0, bus.done}, 32'h0);
    end
    @(posedge clk); #2;
    run_op(32'h0000_0003, 5'd5, 1'b0, 32'h0000_0060, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
